// File: rtl/sdp_bram_lanes_if.sv
// Write/read port bundle for sdp_bram_lanes; master drives requests, slave is the RAM.
interface sdp_bram_lanes_if #(
    parameter int unsigned DATA_W = 75,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LANE_W = 25
);
    localparam int unsigned NUM_LANES = DATA_W / LANE_W;

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_LANES-1:0] wr_mask;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 init_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/sdp_bram_lanes.sv
// Simple dual-port RAM with lane write mask, write-first forwarding and post-reset zero fill.
// Define SDP_BRAM_OUTREG_EN to add a registered output stage (read latency 2 instead of 1).
module sdp_bram_lanes #(
    parameter int unsigned DATA_W = 75,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LANE_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    sdp_bram_lanes_if.slave   bus
);
    localparam int unsigned NUM_LANES = DATA_W / LANE_W;
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e               state_q;
    logic [ADDR_W-1:0]    cnt_q;
    logic                 busy_q;

    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 wr_acc;
    logic                 rd_acc;
    logic [NUM_LANES-1:0] mem_lane_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [NUM_LANES-1:0] fwd_mask_d;

    logic                 v1_q;
    logic [DATA_W-1:0]    ram_q;
    logic [NUM_LANES-1:0] fwd_mask_q;
    logic [DATA_W-1:0]    fwd_data_q;
    logic [DATA_W-1:0]    merge_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: state_q <= ST_RUN;
            endcase
        end
    end

    // The fill sequencer owns the write port while busy; user traffic is dropped.
    always_comb begin
        wr_acc      = bus.wr_en & ~busy_q & ~rst;
        rd_acc      = bus.rd_en & ~busy_q & ~rst;
        mem_lane_we = '0;
        mem_waddr   = bus.wr_addr;
        mem_wdata   = bus.wr_data;
        fwd_mask_d  = '0;
        if (busy_q) begin
            mem_lane_we = rst ? '0 : '1;
            mem_waddr   = cnt_q;
            mem_wdata   = '0;
        end else if (wr_acc) begin
            mem_lane_we = bus.wr_mask;
        end
        if (rd_acc && wr_acc && (bus.rd_addr == bus.wr_addr)) begin
            fwd_mask_d = bus.wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (mem_lane_we[i]) begin
                mem[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read register captures old contents; colliding lanes are patched from fwd_data_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            ram_q      <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                ram_q      <= mem[bus.rd_addr];
                fwd_mask_q <= fwd_mask_d;
                fwd_data_q <= bus.wr_data;
            end
        end
    end

    always_comb begin
        merge_d = ram_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (fwd_mask_q[i]) begin
                merge_d[i*LANE_W +: LANE_W] = fwd_data_q[i*LANE_W +: LANE_W];
            end
        end
    end

`ifdef SDP_BRAM_OUTREG_EN
    logic              v2_q;
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q  <= 1'b0;
            out_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                out_q <= merge_d;
            end
        end
    end

    assign bus.rd_data  = out_q;
    assign bus.rd_valid = v2_q;
`else
    assign bus.rd_data  = merge_d;
    assign bus.rd_valid = v1_q;
`endif

    assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_sdp_bram_lanes.sv
// Scoreboard bench for sdp_bram_lanes (DATA_W=75, ADDR_W=4, LANE_W=25).
module tb_sdp_bram_lanes;
    localparam int unsigned DW    = 75;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 25;
    localparam int unsigned DEPTH = 16;
`ifdef SDP_BRAM_OUTREG_EN
    localparam int unsigned L = 2;
`else
    localparam int unsigned L = 1;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc  = 0;
    int unsigned cyc0 = 32'hFFFF_0000;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t q[$];
    logic [DW-1:0] model [DEPTH];

    sdp_bram_lanes_if #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) bus ();

    sdp_bram_lanes #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: rd_valid=1 at cycle %0d, required no valid", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.rd_data !== e.data || e.due != cyc) begin
                    errors++;
                    $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                             bus.rd_data, cyc, e.data, e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid: rd_valid=%b at cycle %0d, required 1 with %h",
                     bus.rd_valid, cyc, e.data);
        end
    end

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [2:0] wm,
                         input logic re, input logic [AW-1:0] ra);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.wr_mask = wm;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        if (r) begin
            cyc0 = cyc + 1;
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        end else if (cyc >= cyc0 + DEPTH) begin
            if (we) begin
                for (int i = 0; i < 3; i++)
                    if (wm[i]) model[wa][i*LW +: LW] = wd[i*LW +: LW];
            end
            if (re) begin
                e.data = model[ra];
                e.due  = cyc + L;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset;
        repeat (3) drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b required 0", bus.rd_valid);
        end
        checks++;
        if (bus.rd_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h required 0", bus.rd_data);
        end
        checks++;
        if (bus.init_busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b required 1", bus.init_busy);
        end
    endtask

    task automatic test_zero_fill;
        logic [AW-1:0] a;
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            a = k[AW-1:0];
            drive(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
            @(negedge clk);
            checks++;
            if (bus.init_busy !== (k < DEPTH)) begin
                errors++;
                $display("FAIL fill_busy: cycle %0d got %b required %b", k, bus.init_busy, k < DEPTH);
            end
        end
        idle(L + 2);
    endtask

    task automatic test_masked_write;
        drive(1'b0, 1'b1, 4'd3, {DW{1'b1}}, 3'b111, 1'b0, '0);
        drive(1'b0, 1'b1, 4'd3, '0, 3'b010, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
        idle(L + 3);
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== {{LW{1'b1}}, {LW{1'b0}}, {LW{1'b1}}}) begin
            errors++;
            $display("FAIL masked_hold: got valid=%b data=%h required valid=0 data=%h",
                     bus.rd_valid, bus.rd_data, {{LW{1'b1}}, {LW{1'b0}}, {LW{1'b1}}});
        end
    endtask

    task automatic test_collision;
        drive(1'b0, 1'b1, 4'd5, 75'h1, 3'b111, 1'b0, '0);
        drive(1'b0, 1'b1, 4'd5, 75'h2AA, 3'b001, 1'b1, 4'd5);
        drive(1'b0, 1'b1, 4'd5, {DW{1'b1}}, 3'b110, 1'b1, 4'd5);
        idle(L + 3);
        @(negedge clk);
        checks++;
        if (bus.rd_data !== {{(2*LW){1'b1}}, 25'h2AA}) begin
            errors++;
            $display("FAIL collision_hold: got %h required %h", bus.rd_data, {{(2*LW){1'b1}}, 25'h2AA});
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a;
        for (int k = 0; k < DEPTH; k++) begin
            a = k[AW-1:0];
            drive(1'b0, 1'b1, a, DW'(k), 3'b111, 1'b0, '0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            a = k[AW-1:0];
            drive(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
        end
        idle(L + 3);
        @(negedge clk);
        checks++;
        if (bus.rd_data !== DW'(15)) begin
            errors++; $display("FAIL b2b_hold: got %h required %h", bus.rd_data, DW'(15));
        end
    endtask

    task automatic test_reset_mid_op;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd7);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd8);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b1, 4'd9);
        for (int k = 0; k <= DEPTH; k++) begin
            drive(1'b0, k == 10, 4'd7, {DW{1'b1}}, 3'b111, 1'b1, 4'd7);
            @(negedge clk);
            checks++;
            if (bus.init_busy !== (k < DEPTH)) begin
                errors++;
                $display("FAIL refill_busy: cycle %0d got %b required %b", k, bus.init_busy, k < DEPTH);
            end
        end
        idle(L + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset;
        test_zero_fill;
        test_masked_write;
        test_collision;
        test_back_to_back;
        test_reset_mid_op;
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL drain: %0d reads outstanding, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
